// File: rtl/mips_debug_unit.sv
// mips_debug_unit: host-driven debug controller for the MIPS_DLX core.
// Pops one-byte commands from the UART RX FIFO and then free-runs, single-steps
// or freezes the core through enable. After that it streams a snapshot of the
// debug bus, followed by the executed-cycle counter, LSB first, into the TX FIFO.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   rx_data, rx_empty - show-ahead head of the RX FIFO
//   rd                - RX FIFO pop (one-cycle pulse)
//   tx_data, wr       - byte and push strobe towards the TX FIFO
//   tx_full           - TX FIFO back-pressure
//   halt              - core has retired a halt instruction (level)
//   debug_signal      - core debug bus
//   enable            - core clock enable
//   busy              - controller is not idle
module mips_debug_unit #(
  parameter int unsigned DEBUG_W  = 322,
  parameter int unsigned CYC_W    = 32,
  parameter logic [7:0]  CMD_RUN  = 8'h63,
  parameter logic [7:0]  CMD_STEP = 8'h73,
  parameter logic [7:0]  CMD_DUMP = 8'h64,
  parameter logic [7:0]  CMD_STOP = 8'h70
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_empty,
  output logic               rd,
  output logic [7:0]         tx_data,
  input  logic               tx_full,
  output logic               wr,
  input  logic               halt,
  input  logic [DEBUG_W-1:0] debug_signal,
  output logic               enable,
  output logic               busy
);

  localparam int unsigned NB_DBG    = (DEBUG_W + 7) / 8;
  localparam int unsigned NB_CYC    = CYC_W / 8;
  localparam int unsigned NB_TOT    = NB_DBG + NB_CYC;
  localparam int unsigned DBG_PAD_W = 8 * NB_DBG;
  localparam int unsigned SH_W      = 8 * NB_TOT;
  localparam int unsigned IDX_W     = $clog2(NB_TOT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_TOT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RUN,
    S_STEP,
    S_SNAP,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [SH_W-1:0]   shadow_q;
  logic [IDX_W-1:0]  idx_q;
  logic              stop_pop;

  // Stop byte at the FIFO head while running; halt takes priority over it.
  assign stop_pop = (state_q == S_RUN) && !halt && !rx_empty && (rx_data == CMD_STOP);

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    enable  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          rd      = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cmd_q == CMD_RUN)       state_d = S_RUN;
        else if (cmd_q == CMD_STEP) state_d = S_STEP;
        else if (cmd_q == CMD_DUMP) state_d = S_SNAP;
        else                        state_d = S_IDLE;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_SNAP;
        end else if (stop_pop) begin
          rd      = 1'b1;
          state_d = S_SNAP;
        end else begin
          enable  = 1'b1;
        end
      end
      S_STEP: begin
        enable  = 1'b1;
        state_d = S_SNAP;
      end
      S_SNAP: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_full) begin
          wr = 1'b1;
          if (idx_q == LAST_IDX) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The state is already IDLE while reset is held, so keep the FIFOs untouched.
    if (!reset) begin
      rd     = 1'b0;
      wr     = 1'b0;
      enable = 1'b0;
    end
  end

  // State, command latch, cycle counter, snapshot and byte index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= 8'h00;
      cyc_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && rd) cmd_q <= rx_data;
      if (enable) cyc_q <= cyc_q + CYC_W'(1);
      if (state_q == S_SNAP) begin
        // Debug bytes first (zero-padded to whole bytes), counter in the top bytes.
        shadow_q <= {cyc_q, DBG_PAD_W'(debug_signal)};
        idx_q    <= '0;
      end else if (wr) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign tx_data = shadow_q[{idx_q, 3'b000} +: 8];
  assign busy    = (state_q != S_IDLE);

endmodule
